ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port data/program RAM between the core (control unit fetch/load/store path) and a host loader/debug port.
- Fixed core priority with a bounded host wait.
- After the core asserts halt, the host owns the port exclusively.
- Sits between the datapath address/data muxing and the RAM macro; tags read returns so each requester gets only its own data.

Parameters:
ADDR_WIDTH, 5, RAM address width
DATA_WIDTH, 16, RAM data width
RD_LATENCY, 1, RAM read latency in cycles (1..3)
MAX_HOST_WAIT, 4, consecutive cycles host may be refused before it wins one arbitration (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
halt  in  1  core halted (from control unit)
core_req  in  1  core access request
core_we  in  1  core write (1) / read (0)
core_addr  in  ADDR_WIDTH  core address
core_wdata  in  DATA_WIDTH  core write data
core_gnt  out  1  core request accepted this cycle
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_WIDTH  core read data
host_req  in  1  host access request
host_we  in  1  host write / read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data
host_gnt  out  1  host request accepted this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_WIDTH  host read data
ram_addr  out  ADDR_WIDTH  RAM address
ram_we  out  1  RAM write strobe
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, RD_LATENCY after address

Behaviour:
- Clock/reset: one clock clk; reset rst_n asynchronous, active-low.
- Transfer: req & gnt in the same cycle.
  - gnt is combinational from req and registered state.
  - Requesters hold req/we/addr/wdata stable until granted.
- Write: ram_we=1 in the grant cycle; no rvalid.
- Read: owner tag pushed into an RD_LATENCY-deep shift register.
  - Exactly RD_LATENCY cycles after the grant, the owner's rvalid=1 for one cycle; rdata=ram_rdata.
  - Back-to-back reads allowed: one per cycle, any mix of owners.
- rdata holds its last value when rvalid=0. rvalid is never high for both requesters in one cycle.
- No request granted: ram_we=0; ram_addr/ram_wdata hold their previous values.
- FSM states ARB, DRAIN, HOST_ONLY:
  - ARB:
    - core_req wins unless host_wait_cnt==MAX_HOST_WAIT and host_req=1; then host wins and the counter clears.
    - host_wait_cnt increments (saturating) each cycle host_req=1 and host is refused; clears when host is granted or host_req=0.
    - halt=1 with no read in flight -> HOST_ONLY; halt=1 with reads in flight -> DRAIN.
  - DRAIN: core_gnt=0, host_gnt=0; outstanding reads complete normally. Pipeline empty -> HOST_ONLY.
  - HOST_ONLY: core_gnt forced 0; host_gnt=host_req. halt=0 -> ARB with counter cleared.
- Simultaneous events:
  - halt rising in the same cycle as core_req: core not granted.
  - Only host_req: host granted immediately.
  - Only core_req: core granted.
- Reset, including mid-operation:
  - state=ARB; host_wait_cnt=0; tag pipeline cleared, so in-flight reads are dropped and no rvalid is generated.
  - All outputs 0: core_gnt, host_gnt, core_rvalid, host_rvalid, ram_we, ram_addr, ram_wdata, core_rdata, host_rdata.
- Widths: host_wait_cnt is 4 bits, saturating at MAX_HOST_WAIT, no wrap.

Decomposition:
- k_and_s_pkg gets:
  - arb_state_t enum (ARB, DRAIN, HOST_ONLY)
  - owner_t enum (OWN_NONE, OWN_CORE, OWN_HOST)
  - constants ARB_MAX_RD_LATENCY=3 and ARB_WAIT_CNT_W=4
- Sub-module rd_tag_pipe: RD_LATENCY-deep owner_t shift register with an empty flag; drives rvalid routing and the DRAIN exit.

Test Plan:
- Reset, then core read addr 5'h03 (RAM holds 16'hBEEF), RD_LATENCY=1 -> core_gnt same cycle; core_rvalid=1, core_rdata=16'hBEEF one cycle later; host_rvalid stays 0.
- core_req and host_req held high continuously, MAX_HOST_WAIT=4 -> grant pattern core,core,core,core,host repeating; host_wait_cnt never exceeds 4.
- Host write 5'h10<=16'h1234, then core read 5'h10 next cycle -> ram_we=1 in cycle 1 only; core_rdata=16'h1234.
- Core read granted cycle N, halt rises at N+1, RD_LATENCY=3, host_req high -> DRAIN; host_gnt=0 until core_rvalid at N+3; host_gnt=1 at N+4 in HOST_ONLY; core_req ignored.
- rst_n asserted while a host read is in flight -> no host_rvalid after reset release; all outputs 0 during reset; state ARB.
- Alternating core/host reads every cycle, RD_LATENCY=2 -> each rvalid goes to the owner of the grant two cycles earlier; never both rvalid in one cycle.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types and limits for the RAM port arbiter: FSM states, read-owner tags, and
// the widths of the host starvation counter.
package k_and_s_pkg;

  typedef enum logic [1:0] {
    ARB,
    DRAIN,
    HOST_ONLY
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_t;

  localparam int unsigned ARB_MAX_RD_LATENCY = 3;
  localparam int unsigned ARB_WAIT_CNT_W     = 4;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Owner tag shift register that tracks reads in flight through the RAM; the last stage
// names the requester whose data is on ram_rdata this cycle.
module rd_tag_pipe
  import k_and_s_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t push_tag,
  output owner_t out_tag,
  output logic   empty
);

  owner_t tag_q [Depth];
  owner_t tag_d [Depth];

  always_comb begin
    tag_d[0] = push_tag;
    for (int unsigned i = 1; i < Depth; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= OWN_NONE;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign out_tag = tag_q[Depth-1];

  // The last stage retires this cycle, so only earlier stages count as still in flight.
  always_comb begin
    empty = 1'b1;
    for (int unsigned i = 0; i + 1 < Depth; i++) begin
      if (tag_q[i] != OWN_NONE) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port program/data RAM between the core and the host loader port,
// with core priority, bounded host starvation and exclusive host ownership while halted.
module ram_port_arbiter
  import k_and_s_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned MAX_HOST_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  if (RD_LATENCY < 1 || RD_LATENCY > ARB_MAX_RD_LATENCY) begin : g_bad_latency
    $error("RD_LATENCY out of range");
  end
  if (MAX_HOST_WAIT < 1 || MAX_HOST_WAIT > 15) begin : g_bad_wait
    $error("MAX_HOST_WAIT out of range");
  end

  localparam logic [ARB_WAIT_CNT_W-1:0] WaitMax = ARB_WAIT_CNT_W'(MAX_HOST_WAIT);

  arb_state_t                state_q, state_d;
  logic [ARB_WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0]     host_rdata_q, host_rdata_d;
  owner_t                    push_tag, ret_tag;
  logic                      pipe_empty;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ARB: begin
          // The halt cycle grants nobody, so the core can't slip in behind it.
          if (halt) begin
            state_d = pipe_empty ? HOST_ONLY : DRAIN;
          end else if (host_req && (!core_req || wait_q == WaitMax)) begin
            host_gnt = 1'b1;
          end else if (core_req) begin
            core_gnt = 1'b1;
          end
          if (host_gnt || !host_req) begin
            wait_d = '0;
          end else if (wait_q < WaitMax) begin
            wait_d = wait_q + 1'b1;
          end
        end
        DRAIN: begin
          wait_d = '0;
          if (pipe_empty) begin
            state_d = HOST_ONLY;
          end
        end
        HOST_ONLY: begin
          wait_d   = '0;
          host_gnt = host_req;
          if (!halt) begin
            state_d = ARB;
          end
        end
        default: begin
          state_d = ARB;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    push_tag = OWN_NONE;
    if (core_gnt && !core_we) begin
      push_tag = OWN_CORE;
    end else if (host_gnt && !host_we) begin
      push_tag = OWN_HOST;
    end
  end

  // RAM address/data track the granted requester and otherwise hold.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (core_gnt) begin
      ram_we    = core_we;
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
    end else if (host_gnt) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
  end

  rd_tag_pipe #(
    .Depth(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_tag(push_tag),
    .out_tag (ret_tag),
    .empty   (pipe_empty)
  );

  always_comb begin
    core_rvalid  = (ret_tag == OWN_CORE);
    host_rvalid  = (ret_tag == OWN_HOST);
    core_rdata   = core_rvalid ? ram_rdata : core_rdata_q;
    host_rdata   = host_rvalid ? ram_rdata : host_rdata_q;
    core_rdata_d = core_rdata;
    host_rdata_d = host_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      wait_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios then random traffic, all
// compared against a transaction-level model of the arbitration rules.
module tb_ram_port_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int RDL = 3;
  localparam int MHW = 4;

  logic          clk = 1'b0;
  logic          rst_n, halt;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .RD_LATENCY   (RDL),
    .MAX_HOST_WAIT(MHW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt       (halt),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // RAM macro model with RDL-cycle read latency
  logic [DW-1:0] mem   [32];
  logic [DW-1:0] rpipe [RDL];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RDL-1];

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 3) return 16'hBEEF;
    return DW'(i * 257) ^ 16'h5A5A;
  endfunction

  // Reference model: owner mode, starvation count, and a queue of reads due at a cycle
  typedef struct {
    int            due;
    bit            host;
    logic [DW-1:0] data;
  } rd_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            m_mode;  // 0 arbitrate, 1 drain, 2 host only
  int            m_wait;
  rd_t           pend[$];
  logic [DW-1:0] shadow [32];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_crd, m_hrd;
  logic          o_core_gnt, o_host_gnt, o_core_rv, o_host_rv, o_ram_we;
  logic [DW-1:0] o_core_rd, o_host_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_wait  = 0;
    pend.delete();
    m_addr  = '0;
    m_wdata = '0;
    m_crd   = '0;
    m_hrd   = '0;
  endtask

  task automatic cycle();
    bit  ec, eh, ecv, ehv, ewe;
    rd_t r;
    ec  = 0;
    eh  = 0;
    ecv = 0;
    ehv = 0;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_mode)
        0: if (!halt) begin
          if (host_req && (!core_req || m_wait == MHW)) eh = 1;
          else if (core_req) ec = 1;
        end
        2: eh = host_req;
        default: ;
      endcase
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.host) begin
          ehv = 1;
          m_hrd = r.data;
        end else begin
          ecv = 1;
          m_crd = r.data;
        end
      end
    end
    if (ec) begin
      m_addr  = core_addr;
      m_wdata = core_wdata;
    end else if (eh) begin
      m_addr  = host_addr;
      m_wdata = host_wdata;
    end
    ewe = (ec && core_we) || (eh && host_we);

    chk("core_gnt", 32'(core_gnt), 32'(ec));
    chk("host_gnt", 32'(host_gnt), 32'(eh));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    chk("core_rvalid", 32'(core_rvalid), 32'(ecv));
    chk("host_rvalid", 32'(host_rvalid), 32'(ehv));
    chk("core_rdata", 32'(core_rdata), 32'(m_crd));
    chk("host_rdata", 32'(host_rdata), 32'(m_hrd));
    chk("dual_rvalid", 32'(core_rvalid && host_rvalid), 32'(0));

    o_core_gnt = core_gnt;
    o_host_gnt = host_gnt;
    o_core_rv  = core_rvalid;
    o_host_rv  = host_rvalid;
    o_ram_we   = ram_we;
    o_core_rd  = core_rdata;
    o_host_rd  = host_rdata;

    if (rst_n) begin
      if (ec && core_we) shadow[core_addr] = core_wdata;
      if (eh && host_we) shadow[host_addr] = host_wdata;
      if (ec && !core_we) pend.push_back('{due: cyc + RDL, host: 1'b0, data: shadow[core_addr]});
      if (eh && !host_we) pend.push_back('{due: cyc + RDL, host: 1'b1, data: shadow[host_addr]});
      case (m_mode)
        0: begin
          if (eh || !host_req) m_wait = 0;
          else if (m_wait < MHW) m_wait++;
          if (halt) m_mode = (pend.size() > 0) ? 1 : 2;
        end
        1: begin
          m_wait = 0;
          if (pend.size() == 0) m_mode = 2;
        end
        default: begin
          m_wait = 0;
          if (!halt) m_mode = 0;
        end
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_grant(input bit host, input string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(host ? o_host_gnt : o_core_gnt) && n < 50);
    chk(tag, 32'(host ? o_host_gnt : o_core_gnt), 32'(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rvk, cg, nrv;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    for (int i = 0; i < RDL; i++) rpipe[i] = '0;
    model_reset();
    rst_n = 0; halt = 0;
    core_req = 1; core_we = 0; core_addr = 5'h03; core_wdata = '0;
    host_req = 1; host_we = 0; host_addr = 5'h01; host_wdata = '0;

    // Requests held high through reset must not be granted
    idle(2);
    rst_n = 1; core_req = 0; host_req = 0;
    idle(1);

    // Core read of 0x03 returns BEEF RDL cycles later, host sees nothing
    core_req = 1; core_we = 0; core_addr = 5'h03;
    wait_grant(0, "core_rd_gnt");
    core_req = 0;
    idle(RDL);
    chk("beef_rvalid", 32'(o_core_rv), 32'(1));
    chk("beef_data", 32'(o_core_rd), 32'(16'hBEEF));
    chk("beef_host_rvalid", 32'(o_host_rv), 32'(0));

    // Both held high: four core grants then one host grant, repeating
    core_req = 1; core_we = 0; core_addr = 5'h07;
    host_req = 1; host_we = 0; host_addr = 5'h08;
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("pattern", 32'({o_core_gnt, o_host_gnt}), (i % 5 == 4) ? 32'd1 : 32'd2);
    end
    core_req = 0; host_req = 0;
    idle(RDL + 1);

    // Host write then core read of the same word
    host_req = 1; host_we = 1; host_addr = 5'h10; host_wdata = 16'h1234;
    wait_grant(1, "host_wr_gnt");
    chk("host_wr_we", 32'(o_ram_we), 32'(1));
    host_req = 0; host_we = 0;
    core_req = 1; core_we = 0; core_addr = 5'h10;
    wait_grant(0, "core_rd10_gnt");
    chk("core_rd10_we", 32'(o_ram_we), 32'(0));
    core_req = 0;
    idle(RDL);
    chk("rd10_data", 32'(o_core_rd), 32'(16'h1234));

    // Halt right after a core read: drain, then host owns the port
    core_req = 1; core_addr = 5'h03;
    wait_grant(0, "pre_halt_gnt");
    halt = 1; core_addr = 5'h07;
    host_req = 1; host_we = 0; host_addr = 5'h05;
    k = 0; rvk = 0; cg = 0;
    do begin
      cycle();
      k++;
      if (o_core_rv) rvk = k;
      if (o_core_gnt) cg++;
    end while (!o_host_gnt && k < 20);
    chk("drain_host_gnt_cycle", 32'(k), 32'(RDL + 1));
    chk("drain_core_rvalid_cycle", 32'(rvk), 32'(RDL));
    host_req = 0;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (o_core_gnt) cg++;
    end
    chk("halt_core_gnts", 32'(cg), 32'(0));
    halt = 0;
    wait_grant(0, "post_halt_core_gnt");
    core_req = 0;
    idle(RDL + 1);

    // Reset while a host read is in flight drops the return
    host_req = 1; host_we = 0; host_addr = 5'h03;
    wait_grant(1, "host_rd_gnt");
    host_req = 0;
    idle(1);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    nrv = 0;
    for (int i = 0; i < RDL + 1; i++) begin
      cycle();
      if (o_host_rv) nrv++;
    end
    chk("no_rvalid_after_rst", 32'(nrv), 32'(0));

    // Alternating owners, one read per cycle
    for (int i = 0; i < 12; i++) begin
      core_req = (i % 2 == 0); core_we = 0; core_addr = AW'($urandom);
      host_req = (i % 2 == 1); host_we = 0; host_addr = AW'($urandom);
      cycle();
    end
    core_req = 0; host_req = 0;
    idle(RDL + 1);

    // Random traffic with occasional halt and reset
    for (int i = 0; i < 3000; i++) begin
      if (!core_req || o_core_gnt) begin
        core_req = 1'($urandom); core_we = 1'($urandom);
        core_addr = AW'($urandom); core_wdata = DW'($urandom);
      end
      if (!host_req || o_host_gnt) begin
        host_req = 1'($urandom); host_we = 1'($urandom);
        host_addr = AW'($urandom); host_wdata = DW'($urandom);
      end
      if (halt) halt = ($urandom_range(0, 99) >= 10);
      else      halt = ($urandom_range(0, 99) < 3);
      rst_n = ($urandom_range(0, 999) >= 3);
      cycle();
      if (!rst_n) begin
        o_core_gnt = 0;
        o_host_gnt = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
